conv3x3_stream: RTL and testbench

- Streaming, parametrised successor to the flat combinational sobel_filter.
- Accepts a raster-order pixel stream for an IMG_W x IMG_H frame and buffers two rows internally.
- Applies a runtime-loadable signed 3x3 kernel and emits the valid-region (no padding) result stream of (IMG_W-2) x (IMG_H-2) samples.
- Sits between the pixel source and the edge-magnitude/threshold stage; uses valid/ready handshakes on both sides.

---
 rtl/conv3x3_pkg.sv | 32 +++
 rtl/conv3x3_stream_line_buffer.sv | 37 +++
 rtl/conv3x3_stream.sv | 207 ++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared types, constants and arithmetic helpers for the
// streaming 3x3 convolution block (conv3x3_stream, line_buffer2).
package conv3x3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned KTAPS = 9;

  // Row-major k(0,0)..k(2,2): vertical Sobel-style gradient.
  localparam int DEFAULT_KERNEL [KTAPS] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

  // Nine products of an unsigned pixel and a signed coefficient never overflow this.
  function automatic int unsigned acc_width(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 4;
  endfunction

  // Clamp a signed value into the signed out_w-bit range.
  function automatic int sat_signed(input int acc, input int unsigned out_w);
    int hi;
    int lo;
    hi = (1 << (out_w - 1)) - 1;
    lo = -hi - 1;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// line_buffer2: two IMG_W-deep pixel rows. On each write at column col the
// older row takes the younger row's pixel and the younger row takes din.
// Ports:
//   clk       clock
//   we        write strobe (accepted pixel)
//   col       current column index
//   din       incoming pixel
//   tap_r2_c  pixel (r-2, col), combinational
//   tap_r1_c  pixel (r-1, col), combinational
module line_buffer2 #(
  parameter int unsigned PIX_W = 5,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] tap_r2_c,
  output logic [PIX_W-1:0] tap_r1_c
);

  logic [PIX_W-1:0] row_r2 [IMG_W];
  logic [PIX_W-1:0] row_r1 [IMG_W];

  assign tap_r2_c = row_r2[col];
  assign tap_r1_c = row_r1[col];

  // Storage only; contents before two full rows are never consumed.
  always_ff @(posedge clk) begin
    if (we) begin
      row_r2[col] <= row_r1[col];
      row_r1[col] <= din;
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming valid-region 3x3 convolution with a runtime
// loadable signed kernel and valid/ready handshakes on both sides.
// Build option: define ABS_OUT_EN to emit |acc| saturated to unsigned OUT_W.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   coef_load/coef_in  shadow-kernel write strobe and row-major kernel
//   s_valid/s_ready/s_data         raster-order pixel input
//   m_valid/m_ready/m_data/m_last  result output, m_last on final sample
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int unsigned PIX_W  = 5,
  parameter int unsigned COEF_W = 3,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coef_load,
  input  logic [KTAPS*COEF_W-1:0]   coef_in,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [PIX_W-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_W-1:0]          m_data,
  output logic                      m_last
);

  localparam int unsigned ACC_W = acc_width(PIX_W, COEF_W);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned KW    = KTAPS * COEF_W;

  function automatic logic [KW-1:0] pack_default();
    logic [KW-1:0] k;
    k = '0;
    for (int t = 0; t < KTAPS; t++) k[(KTAPS-1-t)*COEF_W +: COEF_W] = COEF_W'(DEFAULT_KERNEL[t]);
    return k;
  endfunction

  localparam logic [KW-1:0] DEF_K = pack_default();

  state_t                  state, state_nx;
  logic                    rst_done;
  logic                    advance, accept;
  logic                    gen_c, last_c, kload_c, at_end_c;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;
  logic [KW-1:0]           kshadow, kact;
  logic [PIX_W-1:0]        tap_r2, tap_r1;
  logic [PIX_W-1:0]        win     [KTAPS];
  logic [PIX_W-1:0]        nwin    [KTAPS];
  logic signed [ACC_W-1:0] prod    [KTAPS];
  logic signed [ACC_W-1:0] prod_nx [KTAPS];
  logic signed [ACC_W-1:0] acc_c;
  logic                    v1, l1;
  logic [OUT_W-1:0]        sat_c;
  int                      sat_i;

  // Whole pipeline moves together; input is held off while output is stalled.
  assign advance  = !m_valid || m_ready;
  assign s_ready  = rst_done && advance;
  assign accept   = s_valid && s_ready;
  assign at_end_c = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

  line_buffer2 #(.PIX_W(PIX_W), .IMG_W(IMG_W), .COL_W(COL_W)) u_lb (
    .clk      (clk),
    .we       (accept),
    .col      (col),
    .din      (s_data),
    .tap_r2_c (tap_r2),
    .tap_r1_c (tap_r1)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-accept output generation.
  always_comb begin
    state_nx = state;
    gen_c    = 1'b0;
    last_c   = 1'b0;
    kload_c  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          kload_c  = 1'b1;
          state_nx = FILL;
        end
        FILL: begin
          if (row >= ROW_W'(2) && col >= COL_W'(2)) begin
            gen_c    = 1'b1;
            state_nx = RUN;
          end
        end
        RUN:     gen_c = (col >= COL_W'(2));
        default: state_nx = IDLE;
      endcase
      if (gen_c && at_end_c) begin
        last_c   = 1'b1;
        state_nx = IDLE;
      end
    end
  end

  // s_ready rises one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Raster position of the next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Shadow kernel takes any load; active kernel latches at frame start,
  // preferring a load arriving in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kshadow <= DEF_K;
      kact    <= DEF_K;
    end else begin
      if (coef_load) kshadow <= coef_in;
      if (kload_c)   kact    <= coef_load ? coef_in : kshadow;
    end
  end

  // Shifted window: column 2 is the new column {r-2, r-1, r}.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nwin[i*3]   = win[i*3+1];
      nwin[i*3+1] = win[i*3+2];
      nwin[i*3+2] = '0;
    end
    nwin[2] = tap_r2;
    nwin[5] = tap_r1;
    nwin[8] = s_data;
    for (int t = 0; t < KTAPS; t++)
      prod_nx[t] = ACC_W'($signed({1'b0, nwin[t]})) *
                   ACC_W'($signed(kact[(KTAPS-1-t)*COEF_W +: COEF_W]));
  end

  // Stage 1: window and products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < KTAPS; t++) begin
        win[t]  <= '0;
        prod[t] <= '0;
      end
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      if (accept) begin
        win  <= nwin;
        prod <= prod_nx;
      end
      if (advance) begin
        v1 <= gen_c;
        l1 <= last_c;
      end
    end
  end

  // Adder tree and output saturation.
  always_comb begin
    acc_c = '0;
    for (int t = 0; t < KTAPS; t++) acc_c = acc_c + prod[t];
`ifdef ABS_OUT_EN
    sat_i = int'(acc_c);
    if (sat_i < 0) sat_i = -sat_i;
    if (sat_i > (1 << OUT_W) - 1) sat_i = (1 << OUT_W) - 1;
`else
    sat_i = sat_signed(int'(acc_c), OUT_W);
`endif
    sat_c = OUT_W'(sat_i);
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (advance) begin
      m_valid <= v1;
      m_last  <= l1;
      if (v1) m_data <= sat_c;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed testbench for conv3x3_stream (28x28 frames, 5-bit pixels, 3-bit
// coefficients, 8-bit output). Honours ABS_OUT_EN for expected values.
module tb_conv3x3_stream;

  localparam int PIX_W = 5, COEF_W = 3, IMG_W = 28, IMG_H = 28, OUT_W = 8;
  localparam int OW = IMG_W - 2, OH = IMG_H - 2;
  localparam int NOUT = OW * OH, NPIX = IMG_W * IMG_H;
  localparam int USE_MODEL = -9999;
  localparam int M_C10 = 0, M_ROW = 1, M_C31 = 2, M_RAMP = 3, M_C7 = 4;

`ifdef ABS_OUT_EN
  localparam int EXP_ROW = 8, EXP_POS = 255, EXP_NEG = 255;
`else
  localparam int EXP_ROW = -8, EXP_POS = 127, EXP_NEG = -128;
`endif

  logic                      clk, rst_n;
  logic                      coef_load;
  logic [9*COEF_W-1:0]       coef_in;
  logic                      s_valid, s_ready;
  logic [PIX_W-1:0]          s_data;
  logic                      m_valid, m_ready, m_last;
  logic [OUT_W-1:0]          m_data;

  int n_vec = 0;
  int n_err = 0;
  int lat_meas;
  int kmodel [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

  conv3x3_stream #(.PIX_W(PIX_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .coef_load(coef_load), .coef_in(coef_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int mode, input int r, input int c);
    case (mode)
      M_C10:   return 10;
      M_ROW:   return r & 31;
      M_C31:   return 31;
      M_RAMP:  return (28 * r + c) % 32;
      default: return 7;
    endcase
  endfunction

  function automatic int model(input int mode, input int r, input int c);
    int acc;
    acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += kmodel[i*3+j] * pix(mode, r + i, c + j);
`ifdef ABS_OUT_EN
    if (acc < 0) acc = -acc;
    if (acc > 255) acc = 255;
`else
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
`endif
    return acc;
  endfunction

  task automatic load_coef(input logic [9*COEF_W-1:0] v);
    @(negedge clk);
    coef_load = 1'b1;
    coef_in   = v;
    @(negedge clk);
    coef_load = 1'b0;
  endtask

  // Streams nfr back-to-back frames and checks every output handshake.
  task automatic run_frames(input string name, input int nfr, input int mode0, input int mode1,
                            input int exp0, input int exp1, input int rdy_pct, input int vld_pct,
                            input int load_at, input logic [9*COEF_W-1:0] load_val, input int rst_at);
    int sent, nout, cyc, budget, acc22, f, q, md, e;
    bit aborted, ld_done;
    logic [7:0] ev;
    sent = 0; nout = 0; cyc = 0; acc22 = -1; aborted = 0; ld_done = 0;
    budget = nfr * NPIX * 8 + 200;
    while ((sent < nfr * NPIX || nout < nfr * NOUT) && cyc < budget) begin
      @(negedge clk);
      coef_load = 1'b0;
      if (rst_at >= 0 && sent == rst_at) begin
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk({name, "_rst_mvalid"}, m_valid, 0);
        chk({name, "_rst_sready"}, s_ready, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      f = sent / NPIX; q = sent % NPIX;
      md = (f == 0) ? mode0 : mode1;
      s_valid = (sent < nfr * NPIX) && ($urandom_range(99) < vld_pct);
      s_data  = PIX_W'(pix(md, q / IMG_W, q % IMG_W));
      m_ready = ($urandom_range(99) < rdy_pct);
      if (load_at >= 0 && !ld_done && sent >= load_at) begin
        coef_load = 1'b1;
        coef_in   = load_val;
        ld_done   = 1;
      end
      #1;
      if (m_valid && !m_ready) chk({name, "_stall_sready"}, s_ready, 0);
      if (m_valid && m_ready) begin
        if (nout == 0) lat_meas = cyc - acc22;
        f = nout / NOUT; q = nout % NOUT;
        md = (f == 0) ? mode0 : mode1;
        e  = (f == 0) ? exp0 : exp1;
        if (e == USE_MODEL) e = model(md, q / OW, q % OW);
        ev = 8'(e);
        chk({name, "_data"}, m_data, ev);
        chk({name, "_last"}, m_last, (q == NOUT - 1));
        nout++;
      end
      if (s_valid && s_ready) begin
        if (sent == 2 * IMG_W + 2) acc22 = cyc;
        sent++;
      end
      cyc++;
    end
    coef_load = 1'b0;
    s_valid   = 1'b0;
    if (cyc >= budget) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_timeout observed=%0d outputs expected=%0d", name, nout, nfr * NOUT);
    end else if (!aborted) begin
      chk({name, "_count"}, nout, nfr * NOUT);
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_no_extra"}, m_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; coef_load = 1'b0; coef_in = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    lat_meas = -1;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready_0", s_ready, 0);
    @(negedge clk);
    #1;
    chk("rel_s_ready_1", s_ready, 1);

    // 1: constant frame, default kernel gives zero everywhere.
    run_frames("t1", 1, M_C10, M_C10, 0, 0, 100, 100, -1, '0, -1);

    // 2: row ramp gives a constant gradient; check latency from pixel (2,2).
    run_frames("t2", 1, M_ROW, M_ROW, EXP_ROW, EXP_ROW, 100, 100, -1, '0, -1);
    chk("t2_latency", lat_meas, 2);

    // 4: random valid/ready against the reference convolution.
    run_frames("t4", 1, M_RAMP, M_RAMP, USE_MODEL, USE_MODEL, 50, 50, -1, '0, -1);

    // 5: mid-frame load affects only the next (back-to-back) frame.
    run_frames("t5", 2, M_ROW, M_C7, EXP_ROW, 63, 100, 100, 400, {9{3'b001}}, -1);

    // 3: positive and negative saturation.
    load_coef({9{3'b011}});
    run_frames("t3a", 1, M_C31, M_C31, EXP_POS, EXP_POS, 100, 100, -1, '0, -1);
    load_coef({9{3'b100}});
    run_frames("t3b", 1, M_C31, M_C31, EXP_NEG, EXP_NEG, 100, 100, -1, '0, -1);

    // 6: reset mid-frame, then a full frame on the restored default kernel.
    run_frames("t6a", 1, M_C31, M_C31, EXP_NEG, EXP_NEG, 100, 100, -1, '0, 300);
    @(negedge clk);
    run_frames("t6b", 1, M_ROW, M_ROW, EXP_ROW, EXP_ROW, 100, 100, -1, '0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
